alu_seq: RTL and testbench

//  Parametrised, handshaked successor to the 8-bit combinational ALU. Adds SPARC-style

---
 rtl/alu_pkg.sv | 40 ++++
 rtl/alu_addsub.sv | 40 ++++
 rtl/alu_seq.sv | 232 +++++++++++++++++++++++
 tb/tb_alu_seq.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared types and constants for the sequential ALU (alu_seq).
//   - op_t      : opcode encoding (0..9 defined, 10..15 undefined)
//   - state_t   : control FSM states
//   - FLAG_*    : bit positions of N, Z, V and C inside the 4-bit icc vector
//   - is_shift_op : true for the three iterative shift opcodes
// ---------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_ADDX = 4'd8,
        ALU_SUBX = 4'd9
    } op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // icc = {N, Z, V, C}
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_addsub.sv
// ---------------------------------------------------------------------------
// alu_addsub
//   Combinational adder/subtractor with carry-in, producing SPARC-style
//   carry/borrow and signed-overflow indications.
//   Ports:
//     a, b  in  WIDTH  operands
//     cin   in  1      carry-in (add) or borrow-in (subtract)
//     sub   in  1      0: a + b + cin, 1: a - b - cin
//     sum   out WIDTH  result modulo 2^WIDTH
//     c     out 1      add: carry out of the MSB; sub: borrow (a < b + cin)
//     v     out 1      signed overflow
// ---------------------------------------------------------------------------
module alu_addsub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             c,
    output logic             v
);

    logic [WIDTH-1:0] b_eff_s;
    logic             cin_eff_s;
    logic [WIDTH:0]   full_s;

    // Subtraction as a + ~b + ~cin: the carry out is then the inverse of the borrow
    always_comb begin
        b_eff_s   = sub ? ~b : b;
        cin_eff_s = sub ? ~cin : cin;
        full_s    = {1'b0, a} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, cin_eff_s};
        sum       = full_s[WIDTH-1:0];
        c         = sub ? ~full_s[WIDTH] : full_s[WIDTH];
        // Overflow when the effective operands agree in sign and the sum does not
        v         = (a[WIDTH-1] == b_eff_s[WIDTH-1]) && (full_s[WIDTH-1] != a[WIDTH-1]);
    end

endmodule

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq
//   Handshaked ALU with integer condition codes and an iterative
//   one-bit-per-cycle shifter. One operation in flight at a time.
//   Ports:
//     clk        in   1      rising-edge clock
//     reset      in   1      asynchronous, active-high reset
//     in_valid   in   1      operands/op presented
//     in_ready   out  1      block can accept (IDLE)
//     a, b       in   WIDTH  operands (shift amount is b[SHAMT_W-1:0])
//     op         in   4      opcode, see alu_pkg::op_t
//     out_valid  out  1      result/flags valid (DONE)
//     out_ready  in   1      consumer accepts result
//     result     out  WIDTH  registered result
//     icc        out  4      committed flags {N,Z,V,C}
//     illegal    out  1      with out_valid: op was undefined
//   Flags are computed alongside the result and committed to icc only on the
//   output handshake, so ADDX/SUBX always see the carry of the previous op.
// ---------------------------------------------------------------------------
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       icc,
    output logic             illegal
);

    state_t             state_r;
    state_t             state_nx_s;

    logic               accept_s;
    logic [SHAMT_W-1:0] shamt_s;
    logic               shift_nz_s;

    logic [WIDTH-1:0]   as_sum_s;
    logic               as_c_s;
    logic               as_v_s;
    logic               as_sub_s;
    logic               as_cin_s;

    logic [WIDTH-1:0]   imm_res_s;
    logic               imm_v_s;
    logic               imm_c_s;
    logic               imm_ill_s;

    logic [WIDTH-1:0]   sh_r;
    logic [3:0]         sop_r;
    logic [SHAMT_W-1:0] cnt_r;
    logic [WIDTH-1:0]   sh_nx_s;
    logic               sh_out_s;
    logic [3:0]         pend_r;

    function automatic logic [3:0] make_flags(input logic [WIDTH-1:0] r,
                                              input logic             v,
                                              input logic             c);
        logic [3:0] f;
        f         = 4'b0000;
        f[FLAG_N] = r[WIDTH-1];
        f[FLAG_Z] = (r == '0);
        f[FLAG_V] = v;
        f[FLAG_C] = c;
        return f;
    endfunction

    assign accept_s   = in_valid & in_ready;
    assign shamt_s    = b[SHAMT_W-1:0];
    assign shift_nz_s = is_shift_op(op) && (shamt_s != '0);
    assign as_sub_s   = (op == ALU_SUB) || (op == ALU_SUBX);
    // Only the X variants chain the committed carry
    assign as_cin_s   = ((op == ALU_ADDX) || (op == ALU_SUBX)) & icc[FLAG_C];

    alu_addsub #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .a   (a),
        .b   (b),
        .cin (as_cin_s),
        .sub (as_sub_s),
        .sum (as_sum_s),
        .c   (as_c_s),
        .v   (as_v_s)
    );

    // Single-cycle result for all ops that finish straight from IDLE
    always_comb begin
        imm_res_s = '0;
        imm_v_s   = 1'b0;
        imm_c_s   = 1'b0;
        imm_ill_s = 1'b0;
        case (op)
            ALU_ADD, ALU_SUB, ALU_ADDX, ALU_SUBX: begin
                imm_res_s = as_sum_s;
                imm_v_s   = as_v_s;
                imm_c_s   = as_c_s;
            end
            ALU_AND: imm_res_s = a & b;
            ALU_OR:  imm_res_s = a | b;
            ALU_XOR: imm_res_s = a ^ b;
            // Zero-amount shift: pass a through with C=0
            ALU_SLL, ALU_SRL, ALU_SRA: imm_res_s = a;
            default: imm_ill_s = 1'b1;
        endcase
    end

    // One-bit shift step on the captured operand; sh_out_s is the bit leaving
    always_comb begin
        sh_nx_s  = sh_r;
        sh_out_s = 1'b0;
        case (sop_r)
            ALU_SLL: begin
                sh_nx_s  = {sh_r[WIDTH-2:0], 1'b0};
                sh_out_s = sh_r[WIDTH-1];
            end
            ALU_SRL: begin
                sh_nx_s  = {1'b0, sh_r[WIDTH-1:1]};
                sh_out_s = sh_r[0];
            end
            ALU_SRA: begin
                sh_nx_s  = {sh_r[WIDTH-1], sh_r[WIDTH-1:1]};
                sh_out_s = sh_r[0];
            end
            default: begin
                sh_nx_s  = sh_r;
                sh_out_s = 1'b0;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (shift_nz_s) begin
                        state_nx_s = SHIFT;
                    end else begin
                        state_nx_s = DONE;
                    end
                end else begin
                    state_nx_s = IDLE;
                end
            end
            SHIFT: begin
                // cnt_r counts the shifts still to do, including this cycle's
                if (cnt_r == SHAMT_W'(1)) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = SHIFT;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = DONE;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // Handshake outputs, operand capture, shift datapath, result/flag registers and flag commit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            icc       <= 4'b0000;
            illegal   <= 1'b0;
            sh_r      <= '0;
            sop_r     <= 4'd0;
            cnt_r     <= '0;
            pend_r    <= 4'b0000;
        end else begin
            in_ready  <= (state_nx_s == IDLE);
            out_valid <= (state_nx_s == DONE);
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        sh_r  <= a;
                        sop_r <= op;
                        cnt_r <= shamt_s;
                        if (!shift_nz_s) begin
                            result  <= imm_res_s;
                            illegal <= imm_ill_s;
                            pend_r  <= make_flags(imm_res_s, imm_v_s, imm_c_s);
                        end
                    end
                end
                SHIFT: begin
                    sh_r  <= sh_nx_s;
                    cnt_r <= cnt_r - SHAMT_W'(1);
                    if (cnt_r == SHAMT_W'(1)) begin
                        result  <= sh_nx_s;
                        illegal <= 1'b0;
                        pend_r  <= make_flags(sh_nx_s, 1'b0, sh_out_s);
                    end
                end
                DONE: begin
                    // Undefined ops leave the committed flags untouched
                    if (out_ready && !illegal) begin
                        icc <= pend_r;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq: directed WIDTH=8 cases plus a WIDTH=32 random
// regression, both checked through a queue-based scoreboard.
module tb_alu_seq;

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  icc;
        logic        ill;
        logic [7:0]  lat;
        logic [31:0] acc;
    } exp_t;

    logic        clk;
    logic        reset;

    logic        in_valid8, in_ready8, out_valid8, out_ready8, illegal8;
    logic [7:0]  a8, b8, result8;
    logic [3:0]  op8, icc8;

    logic        in_valid32, in_ready32, out_valid32, out_ready32, illegal32;
    logic [31:0] a32, b32, result32;
    logic [3:0]  op32, icc32;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] cyc = 32'd0;
    exp_t        q8[$];
    exp_t        q32[$];
    logic [3:0]  m_icc8 = 4'd0;
    logic [3:0]  m_icc32 = 4'd0;
    bit          vis8 = 0, vis32 = 0, due8 = 0, due32 = 0, rnd_on = 0;
    logic [3:0]  dicc8, dicc32;
    int          iss32 = 0, got32 = 0;

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .op(op8), .out_valid(out_valid8), .out_ready(out_ready8),
        .result(result8), .icc(icc8), .illegal(illegal8)
    );

    alu_seq #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .in_valid(in_valid32), .in_ready(in_ready32),
        .a(a32), .b(b32), .op(op32), .out_valid(out_valid32), .out_ready(out_ready32),
        .result(result32), .icc(icc32), .illegal(illegal32)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 32'd1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: plain arithmetic on w-bit values held in 64 bits
    function automatic exp_t model(input int w, input logic [3:0] o, input logic [31:0] a,
                                   input logic [31:0] b, input logic [3:0] fl);
        exp_t e;
        logic [63:0] m, ua, ub, r, full, sx, ci;
        int k;
        logic v, c;
        m    = (64'd1 << w) - 64'd1;
        ua   = {32'd0, a} & m;
        ub   = {32'd0, b} & m;
        k    = int'(ub % 64'(w));
        ci   = ((o == 4'd8) || (o == 4'd9)) ? {63'd0, fl[0]} : 64'd0;
        r    = 64'd0;
        v    = 1'b0;
        c    = 1'b0;
        e    = '0;
        e.lat = 8'd1;
        case (o)
            4'd0, 4'd8: begin
                full = ua + ub + ci;
                r = full & m;
                c = full[w];
                v = (ua[w-1] == ub[w-1]) && (r[w-1] != ua[w-1]);
            end
            4'd1, 4'd9: begin
                c = (ua < ub + ci);
                r = (ua - ub - ci) & m;
                v = (ua[w-1] != ub[w-1]) && (r[w-1] != ua[w-1]);
            end
            4'd2: r = ua & ub;
            4'd3: r = ua | ub;
            4'd4: r = ua ^ ub;
            4'd5: begin
                r = (ua << k) & m;
                c = (k != 0) ? ua[w-k] : 1'b0;
                e.lat = 8'(k + 1);
            end
            4'd6: begin
                r = ua >> k;
                c = (k != 0) ? ua[k-1] : 1'b0;
                e.lat = 8'(k + 1);
            end
            4'd7: begin
                sx = ua[w-1] ? (ua | ~m) : ua;
                r = (sx >> k) & m;
                c = (k != 0) ? ua[k-1] : 1'b0;
                e.lat = 8'(k + 1);
            end
            default: e.ill = 1'b1;
        endcase
        e.res = r[31:0];
        e.icc = e.ill ? fl : {r[w-1], (r == 64'd0), v, c};
        return e;
    endfunction

    // Present one op to the selected instance and push its expectation once accepted
    task automatic issue(input bit w32, input logic [3:0] o, input logic [31:0] aa, input logic [31:0] bb);
        exp_t e;
        int g;
        logic rdy;
        g = 0;
        @(posedge clk); #1;
        if (w32) begin
            in_valid32 = 1'b1; op32 = o; a32 = aa; b32 = bb;
        end else begin
            in_valid8 = 1'b1; op8 = o; a8 = aa[7:0]; b8 = bb[7:0];
        end
        @(negedge clk);
        rdy = w32 ? in_ready32 : in_ready8;
        while (!rdy && g < 200) begin
            @(negedge clk);
            g++;
            rdy = w32 ? in_ready32 : in_ready8;
        end
        if (!rdy) begin
            chk(w32 ? "accept32" : "accept8", {63'd0, rdy}, 64'd1);
        end else if (w32) begin
            e = model(32, o, aa, bb, m_icc32);
            e.acc = cyc;
            m_icc32 = e.icc;
            q32.push_back(e);
            iss32++;
        end else begin
            e = model(8, o, {24'd0, aa[7:0]}, {24'd0, bb[7:0]}, m_icc8);
            e.acc = cyc;
            m_icc8 = e.icc;
            q8.push_back(e);
        end
        @(posedge clk); #1;
        // Scramble inputs after accept: the DUT must have captured them
        if (w32) begin
            in_valid32 = 1'b0; a32 = $urandom; b32 = $urandom; op32 = 4'($urandom);
        end else begin
            in_valid8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); op8 = 4'($urandom);
        end
    endtask

    task automatic wait_idle8();
        int g;
        g = 0;
        @(negedge clk);
        while (!in_ready8 && g < 200) begin
            @(negedge clk);
            g++;
        end
        chk("idle8", {63'd0, in_ready8}, 64'd1);
    endtask

    // Monitor for the 8-bit instance
    always @(negedge clk) begin : mon8
        exp_t e;
        if (reset) begin
            q8.delete();
            vis8 = 0;
            due8 = 0;
        end else begin
            if (due8) begin
                chk("icc8", {60'd0, icc8}, {60'd0, dicc8});
                due8 = 0;
            end
            if (out_valid8) begin
                if (q8.size() == 0) begin
                    chk("spurious8", 64'(q8.size()), 64'd1);
                end else begin
                    if (!vis8) begin
                        vis8 = 1;
                        chk("lat8", 64'(cyc - q8[0].acc), 64'(q8[0].lat));
                    end
                    if (out_ready8) begin
                        e = q8.pop_front();
                        chk("res8", {56'd0, result8}, {56'd0, e.res[7:0]});
                        chk("ill8", {63'd0, illegal8}, {63'd0, e.ill});
                        dicc8 = e.icc;
                        due8 = 1;
                        vis8 = 0;
                    end
                end
            end
        end
    end

    // Monitor for the 32-bit instance
    always @(negedge clk) begin : mon32
        exp_t e;
        if (reset) begin
            q32.delete();
            vis32 = 0;
            due32 = 0;
        end else begin
            if (due32) begin
                chk("icc32", {60'd0, icc32}, {60'd0, dicc32});
                due32 = 0;
            end
            if (out_valid32) begin
                if (q32.size() == 0) begin
                    chk("spurious32", 64'(q32.size()), 64'd1);
                end else begin
                    if (!vis32) begin
                        vis32 = 1;
                        chk("lat32", 64'(cyc - q32[0].acc), 64'(q32[0].lat));
                    end
                    if (out_ready32) begin
                        e = q32.pop_front();
                        chk("res32", {32'd0, result32}, {32'd0, e.res});
                        chk("ill32", {63'd0, illegal32}, {63'd0, e.ill});
                        dicc32 = e.icc;
                        due32 = 1;
                        vis32 = 0;
                        got32++;
                    end
                end
            end
        end
    end

    // Random backpressure on the 32-bit consumer
    initial begin
        out_ready32 = 1'b1;
        forever begin
            @(posedge clk); #1;
            out_ready32 = rnd_on ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    initial begin
        int g;
        logic [3:0] o;
        reset = 1'b1;
        in_valid8 = 1'b0; a8 = 8'd0; b8 = 8'd0; op8 = 4'd0; out_ready8 = 1'b1;
        in_valid32 = 1'b0; a32 = 32'd0; b32 = 32'd0; op32 = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {63'd0, in_ready8}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid8}, 64'd0);
        chk("rst_result", {56'd0, result8}, 64'd0);
        chk("rst_icc", {60'd0, icc8}, 64'd0);
        chk("rst_illegal", {63'd0, illegal8}, 64'd0);
        reset = 1'b0;

        issue(1'b0, 4'd0, 32'h7F, 32'h01);
        wait_idle8();
        chk("add_res", {56'd0, result8}, 64'h80);
        chk("add_icc", {60'd0, icc8}, 64'b1010);

        // Reset three cycles into a 7-cycle SLL
        issue(1'b0, 4'd5, 32'h01, 32'h07);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("rstsh_out_valid", {63'd0, out_valid8}, 64'd0);
        chk("rstsh_in_ready", {63'd0, in_ready8}, 64'd1);
        chk("rstsh_icc", {60'd0, icc8}, 64'd0);
        @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        m_icc8 = 4'd0;
        m_icc32 = 4'd0;

        issue(1'b0, 4'd1, 32'h00, 32'h01);
        wait_idle8();
        chk("sub_res", {56'd0, result8}, 64'hFF);
        chk("sub_icc", {60'd0, icc8}, 64'b1001);

        issue(1'b0, 4'd0, 32'hFF, 32'h01);
        wait_idle8();
        chk("addc_icc", {60'd0, icc8}, 64'b0101);
        issue(1'b0, 4'd8, 32'h00, 32'h00);
        wait_idle8();
        chk("addx_res", {56'd0, result8}, 64'h01);
        chk("addx_icc", {60'd0, icc8}, 64'b0000);

        issue(1'b0, 4'd7, 32'h90, 32'h03);
        wait_idle8();
        chk("sra_res", {56'd0, result8}, 64'hF2);
        chk("sra_icc", {60'd0, icc8}, 64'b1000);
        issue(1'b0, 4'd5, 32'h81, 32'h01);
        wait_idle8();
        chk("sll_res", {56'd0, result8}, 64'h02);
        chk("sll_icc", {60'd0, icc8}, 64'b0001);

        // Consumer stalls for 5 cycles in DONE
        out_ready8 = 1'b0;
        issue(1'b0, 4'd4, 32'h0F, 32'hFF);
        g = 0;
        while (!out_valid8 && g < 20) begin
            @(negedge clk);
            g++;
        end
        repeat (5) begin
            @(negedge clk);
            chk("hold_valid", {63'd0, out_valid8}, 64'd1);
            chk("hold_res", {56'd0, result8}, 64'hF0);
            chk("hold_in_ready", {63'd0, in_ready8}, 64'd0);
            chk("hold_icc", {60'd0, icc8}, 64'b0001);
        end
        @(posedge clk); #1;
        out_ready8 = 1'b1;
        wait_idle8();
        chk("xor_icc", {60'd0, icc8}, 64'b1000);

        issue(1'b0, 4'd12, 32'h55, 32'hAA);
        wait_idle8();
        chk("illegal_flag", {63'd0, illegal8}, 64'd1);
        chk("illegal_res", {56'd0, result8}, 64'd0);
        chk("illegal_icc", {60'd0, icc8}, 64'b1000);
        chk("drain8", 64'(q8.size()), 64'd0);

        // WIDTH=32 random regression with random gaps and backpressure
        rnd_on = 1;
        repeat (300) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
            end
            if ($urandom_range(0, 7) == 0) o = 4'($urandom_range(10, 15));
            else o = 4'($urandom_range(0, 9));
            issue(1'b1, o, $urandom, $urandom);
        end
        g = 0;
        while ((q32.size() != 0 || due32) && g < 2000) begin
            @(negedge clk);
            g++;
        end
        chk("drain32", 64'(q32.size()), 64'd0);
        chk("count32", 64'(got32), 64'(iss32));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
